// File: rtl/channel_worker_rsp.sv
// channel_worker_rsp: A/B fork-join responder answering on channel C.
// Optional stall watchdog compiled in with CHANNEL_WORKER_WATCHDOG_EN.
module channel_worker_rsp #(
    parameter int WIDTH    = 8,
    parameter int RESP_VAL = 42,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             c_valid,
    output logic [WIDTH-1:0] c_data,
    input  logic             c_ready,
    output logic [CNT_W-1:0] txn_count,
    output logic             stall
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        SEND
    } state_t;

    localparam logic [WIDTH-1:0] RESP_W = WIDTH'(RESP_VAL);

    state_t           state_q, state_d;
    logic             a_ready_q, a_ready_d;
    logic             b_ready_q, b_ready_d;
    logic             a_got_q, a_got_d;
    logic             b_got_q, b_got_d;
    logic [WIDTH-1:0] flag_q, flag_d;
    logic             c_valid_q, c_valid_d;
    logic [WIDTH-1:0] c_data_q, c_data_d;
    logic [CNT_W-1:0] txn_q, txn_d;

    logic a_hs, b_hs, c_hs, any_hs;

    // Readies are only ever high in RECV, c_valid only in SEND.
    assign a_hs   = a_valid && a_ready_q;
    assign b_hs   = b_valid && b_ready_q;
    assign c_hs   = c_valid_q && c_ready;
    assign any_hs = a_hs || b_hs || c_hs;

    // Next-state and output-register logic for the fork/join sequencer.
    always_comb begin
        state_d   = state_q;
        a_ready_d = a_ready_q;
        b_ready_d = b_ready_q;
        a_got_d   = a_got_q;
        b_got_d   = b_got_q;
        flag_d    = flag_q;
        c_valid_d = c_valid_q;
        c_data_d  = c_data_q;
        txn_d     = txn_q;
        unique case (state_q)
            IDLE: begin
                state_d   = RECV;
                a_ready_d = 1'b1;
                b_ready_d = 1'b1;
                a_got_d   = 1'b0;
                b_got_d   = 1'b0;
            end
            RECV: begin
                if (a_hs) begin
                    a_got_d   = 1'b1;
                    a_ready_d = 1'b0;
                    flag_d    = a_data;
                end
                // B is applied last so it wins a same-edge tie.
                if (b_hs) begin
                    b_got_d   = 1'b1;
                    b_ready_d = 1'b0;
                    flag_d    = b_data;
                end
                if (a_got_d && b_got_d) begin
                    state_d   = SEND;
                    a_ready_d = 1'b0;
                    b_ready_d = 1'b0;
                    c_valid_d = 1'b1;
                    c_data_d  = (flag_d != '0) ? RESP_W : '0;
                end
            end
            SEND: begin
                if (c_hs) begin
                    state_d   = RECV;
                    c_valid_d = 1'b0;
                    txn_d     = txn_q + 1'b1;
                    a_ready_d = 1'b1;
                    b_ready_d = 1'b1;
                    a_got_d   = 1'b0;
                    b_got_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_ready_q <= 1'b0;
            b_ready_q <= 1'b0;
            a_got_q   <= 1'b0;
            b_got_q   <= 1'b0;
            flag_q    <= '0;
            c_valid_q <= 1'b0;
            c_data_q  <= '0;
            txn_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_ready_q <= a_ready_d;
            b_ready_q <= b_ready_d;
            a_got_q   <= a_got_d;
            b_got_q   <= b_got_d;
            flag_q    <= flag_d;
            c_valid_q <= c_valid_d;
            c_data_q  <= c_data_d;
            txn_q     <= txn_d;
        end
    end

    assign a_ready   = a_ready_q;
    assign b_ready   = b_ready_q;
    assign c_valid   = c_valid_q;
    assign c_data    = c_data_q;
    assign txn_count = txn_q;

`ifdef CHANNEL_WORKER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            stall_q, stall_d;

    // Count quiet cycles, restarting on any handshake or state change.
    always_comb begin
        wd_d = wd_q;
        if (any_hs || (state_d != state_q)) begin
            wd_d = '0;
        end else if ((state_q != IDLE) && (wd_q != WD_MAX)) begin
            wd_d = wd_q + 1'b1;
        end
        stall_d = (wd_d == WD_MAX);
    end

    // Watchdog counter and registered stall flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    logic unused_ok;
    assign unused_ok = any_hs;
    assign stall     = 1'b0;
`endif

endmodule

// File: tb/tb_channel_worker_rsp.sv
// Directed testbench for channel_worker_rsp.
// Stall expectations follow CHANNEL_WORKER_WATCHDOG_EN.
module tb_channel_worker_rsp;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             rst;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             c_valid;
    logic [WIDTH-1:0] c_data;
    logic             c_ready;
    logic [CNT_W-1:0] txn_count;
    logic             stall;

    int tests;
    int fails;
    int exp_txn;

    channel_worker_rsp #(
        .WIDTH   (WIDTH),
        .RESP_VAL(42),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .c_valid  (c_valid),
        .c_data   (c_data),
        .c_ready  (c_ready),
        .txn_count(txn_count),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        tests++;
        if ({a_ready, b_ready, c_valid, stall} !== 4'b0000) begin
            fails++;
            $display("FAIL %s_flags got %b%b%b%b want 0000",
                     tag, a_ready, b_ready, c_valid, stall);
        end
        tests++;
        if (c_data !== 8'd0) begin
            fails++;
            $display("FAIL %s_c_data got %0d want 0", tag, c_data);
        end
        tests++;
        if (txn_count !== 16'd0) begin
            fails++;
            $display("FAIL %s_txn got %0d want 0", tag, txn_count);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!(a_ready === 1'b1 && b_ready === 1'b1) && n < 4) begin
            tick();
            n++;
        end
        tests++;
        if (!(a_ready === 1'b1 && b_ready === 1'b1) || n > 2) begin
            fails++;
            $display("FAIL %s_ready got %b%b after %0d edges want 11 within 2",
                     tag, a_ready, b_ready, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 0; b_valid = 0; c_ready = 0;
        a_data = 0; b_data = 0;
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        wait_ready("reset");
        exp_txn = 0;
    endtask

    task automatic test_simultaneous(input logic [7:0] av,
                                     input logic [7:0] bv,
                                     input logic [7:0] exp_c);
        a_valid = 1; a_data = av;
        b_valid = 1; b_data = bv;
        c_ready = 1;
        tick();
        a_valid = 0; b_valid = 0;
        tests++;
        if (c_valid !== 1'b1 || c_data !== exp_c) begin
            fails++;
            $display("FAIL simul_c got v=%b d=%0d want v=1 d=%0d",
                     c_valid, c_data, exp_c);
        end
        tests++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            fails++;
            $display("FAIL simul_rdy got %b%b want 00", a_ready, b_ready);
        end
        tick();
        exp_txn++;
        tests++;
        if (c_valid !== 1'b0 || txn_count !== 16'(exp_txn)) begin
            fails++;
            $display("FAIL simul_done got v=%b txn=%0d want v=0 txn=%0d",
                     c_valid, txn_count, exp_txn);
        end
        tests++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            fails++;
            $display("FAIL simul_rerdy got %b%b want 11", a_ready, b_ready);
        end
    endtask

    task automatic test_ordered();
        c_ready = 0;
        a_valid = 1; a_data = 8'd7;
        tick();
        a_valid = 0;
        tests++;
        if (a_ready !== 1'b0 || b_ready !== 1'b1 || c_valid !== 1'b0) begin
            fails++;
            $display("FAIL ord_a got ar=%b br=%b cv=%b want 0 1 0",
                     a_ready, b_ready, c_valid);
        end
        tick();
        tick();
        tests++;
        if (a_ready !== 1'b0 || c_valid !== 1'b0) begin
            fails++;
            $display("FAIL ord_wait got ar=%b cv=%b want 0 0", a_ready, c_valid);
        end
        b_valid = 1; b_data = 8'd0;
        tick();
        b_valid = 0;
        tests++;
        if (c_valid !== 1'b1 || c_data !== 8'd0 || a_ready !== 1'b0) begin
            fails++;
            $display("FAIL ord_c got v=%b d=%0d ar=%b want 1 0 0",
                     c_valid, c_data, a_ready);
        end
        c_ready = 1;
        tick();
        exp_txn++;
        tests++;
        if (c_valid !== 1'b0 || txn_count !== 16'(exp_txn) || a_ready !== 1'b1) begin
            fails++;
            $display("FAIL ord_done got v=%b txn=%0d ar=%b want 0 %0d 1",
                     c_valid, txn_count, a_ready, exp_txn);
        end
    endtask

    task automatic test_b_first(input logic [7:0] bv,
                                input logic [7:0] av,
                                input logic [7:0] exp_c);
        c_ready = 0;
        b_valid = 1; b_data = bv;
        tick();
        b_valid = 0;
        tests++;
        if (b_ready !== 1'b0 || a_ready !== 1'b1) begin
            fails++;
            $display("FAIL bfirst_b got ar=%b br=%b want 1 0", a_ready, b_ready);
        end
        a_valid = 1; a_data = av;
        tick();
        a_valid = 0;
        tests++;
        if (c_valid !== 1'b1 || c_data !== exp_c) begin
            fails++;
            $display("FAIL bfirst_c got v=%b d=%0d want v=1 d=%0d",
                     c_valid, c_data, exp_c);
        end
        c_ready = 1;
        tick();
        exp_txn++;
        tests++;
        if (txn_count !== 16'(exp_txn)) begin
            fails++;
            $display("FAIL bfirst_txn got %0d want %0d", txn_count, exp_txn);
        end
    endtask

    task automatic test_hold();
        c_ready = 0;
        a_valid = 1; a_data = 8'd1;
        b_valid = 1; b_data = 8'd1;
        tick();
        for (int i = 0; i < 10; i++) begin
            a_valid = i[0];
            b_valid = ~i[0];
            a_data  = 8'(i);
            b_data  = 8'(i + 3);
            tick();
            tests++;
            if (c_valid !== 1'b1 || c_data !== 8'd42 ||
                a_ready !== 1'b0 || b_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_%0d got v=%b d=%0d rdy=%b%b want 1 42 00",
                         i, c_valid, c_data, a_ready, b_ready);
            end
        end
        a_valid = 0; b_valid = 0;
        c_ready = 1;
        tick();
        exp_txn++;
        tests++;
        if (c_valid !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1 ||
            txn_count !== 16'(exp_txn)) begin
            fails++;
            $display("FAIL hold_rel got v=%b rdy=%b%b txn=%0d want 0 11 %0d",
                     c_valid, a_ready, b_ready, txn_count, exp_txn);
        end
    endtask

    task automatic test_watchdog();
        logic exp_stall;
`ifdef CHANNEL_WORKER_WATCHDOG_EN
        exp_stall = 1'b1;
`else
        exp_stall = 1'b0;
`endif
        c_ready = 0;
        a_valid = 1; a_data = 8'd4;
        tick();
        a_valid = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL wd_early got %b want 0", stall);
        end
        tick();
        tests++;
        if (stall !== exp_stall) begin
            fails++;
            $display("FAIL wd_stall got %b want %b", stall, exp_stall);
        end
        tick();
        tests++;
        if (stall !== exp_stall) begin
            fails++;
            $display("FAIL wd_hold got %b want %b", stall, exp_stall);
        end
        b_valid = 1; b_data = 8'd0;
        tick();
        b_valid = 0;
        tests++;
        if (stall !== 1'b0 || c_valid !== 1'b1 || c_data !== 8'd0) begin
            fails++;
            $display("FAIL wd_clear got st=%b v=%b d=%0d want 0 1 0",
                     stall, c_valid, c_data);
        end
        c_ready = 1;
        tick();
        exp_txn++;
        tests++;
        if (txn_count !== 16'(exp_txn)) begin
            fails++;
            $display("FAIL wd_txn got %0d want %0d", txn_count, exp_txn);
        end
    endtask

    task automatic test_reset_mid();
        c_ready = 0;
        a_valid = 1; a_data = 8'd2;
        b_valid = 1; b_data = 8'd2;
        tick();
        a_valid = 0; b_valid = 0;
        tests++;
        if (c_valid !== 1'b1 || txn_count !== 16'(exp_txn)) begin
            fails++;
            $display("FAIL rmid_pre got v=%b txn=%0d want 1 %0d",
                     c_valid, txn_count, exp_txn);
        end
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("rmid");
        tick();
        rst = 1'b0;
        wait_ready("rmid");
        exp_txn = 0;
        test_simultaneous(8'd6, 8'd1, 8'd42);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_txn = 0;
        test_reset();
        test_simultaneous(8'd0, 8'd5, 8'd42);
        test_ordered();
        test_b_first(8'd9, 8'd0, 8'd0);
        test_simultaneous(8'd3, 8'd0, 8'd0);
        test_b_first(8'd0, 8'd9, 8'd42);
        test_hold();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
